// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM modulator/demodulator defaults
package pdm_pkg;
  localparam int PDM_WIDTH      = 5;
  localparam int PDM_FRAME_LOG2 = 5;
endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, async active-high reset to 0
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pdm_demod.sv
// rtl/pdm_demod.sv - decimating PDM demodulator: count ones per frame, scale, saturate
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int WIDTH      = PDM_WIDTH,
  parameter int FRAME_LOG2 = PDM_FRAME_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_in,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             sample_sat
);
  localparam int SHIFT = FRAME_LOG2 - WIDTH;
  localparam logic [FRAME_LOG2:0] SAT_MAX = (FRAME_LOG2+1)'((1 << WIDTH) - 1);

  generate
    if (FRAME_LOG2 < WIDTH) begin : g_bad_params
      $error("pdm_demod: FRAME_LOG2 must be >= WIDTH");
    end
  endgenerate

  logic                  b;
  logic [FRAME_LOG2-1:0] frame_cnt;
  logic [FRAME_LOG2:0]   acc;
  logic [FRAME_LOG2:0]   t;
  logic [FRAME_LOG2:0]   s;
  logic                  frame_last;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pdm_in),
    .q     (b)
  );

  // Only a full frame of ones can exceed the WIDTH-bit range after scaling.
  assign t          = acc + {{FRAME_LOG2{1'b0}}, b};
  assign s          = t >> SHIFT;
  assign frame_last = (frame_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt    <= '0;
      acc          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_sat   <= 1'b0;
    end else if (clear) begin
      frame_cnt    <= '0;
      acc          <= '0;
      sample_valid <= 1'b0;
    end else if (!en) begin
      sample_valid <= 1'b0;
    end else if (!frame_last) begin
      acc          <= t;
      frame_cnt    <= frame_cnt + FRAME_LOG2'(1);
      sample_valid <= 1'b0;
    end else begin
      sample       <= (s > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : s[WIDTH-1:0];
      sample_sat   <= (s > SAT_MAX);
      sample_valid <= 1'b1;
      acc          <= '0;
      frame_cnt    <= '0;
    end
  end
endmodule

// File: tb/tb_pdm_demod.sv
// tb/tb_pdm_demod.sv - directed self-checking bench for pdm_demod
module tb_pdm_demod;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pdm_in = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] sample;
  logic       sample_valid;
  logic       sample_sat;

  int vectors = 0;
  int errors  = 0;
  int mode    = 0;    // 0 constant level, 1 toggle, 2 first-order sigma-delta
  int level   = 0;
  int sd_acc  = 0;
  int sd_in   = 10;
  int n;
  int total;

  pdm_demod dut (
    .clk          (clk),
    .reset        (reset),
    .pdm_in       (pdm_in),
    .en           (en),
    .clear        (clear),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_sat   (sample_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_bit();
    case (mode)
      0: pdm_in = level[0];
      1: pdm_in = ~pdm_in;
      default: begin
        sd_acc = sd_acc + sd_in;
        if (sd_acc >= 32) begin
          pdm_in = 1'b1;
          sd_acc = sd_acc - 32;
        end else begin
          pdm_in = 1'b0;
        end
      end
    endcase
  endtask

  task automatic tick();
    drive_bit();
    @(negedge clk);
  endtask

  // Counts edges until the strobe is seen; an expired bound shows as a wrong count.
  task automatic wait_strobe(input int max, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!sample_valid && cycles < max);
  endtask

  task automatic do_reset(input int m, input int lvl);
    mode   = m;
    level  = lvl;
    sd_acc = 0;
    pdm_in = 1'b0;
    en     = 1'b1;
    clear  = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_sat", sample_sat, 0);

    // Constant 0: two strobes 32 apart
    do_reset(0, 0);
    wait_strobe(64, n);
    check("zero_first_latency", n, 32);
    check("zero_sample", sample, 0);
    check("zero_sat", sample_sat, 0);
    tick();
    check("zero_pulse_width", sample_valid, 0);
    wait_strobe(64, n);
    check("zero_period", n + 1, 32);
    check("zero_sample2", sample, 0);

    // Constant 1: 30 first (two sync zeros), then saturated 31
    do_reset(0, 1);
    wait_strobe(64, n);
    check("one_first_latency", n, 32);
    check("one_first_sample", sample, 30);
    check("one_first_sat", sample_sat, 0);
    wait_strobe(64, n);
    check("one_period", n, 32);
    check("one_sat_sample", sample, 31);
    check("one_sat_flag", sample_sat, 1);
    tick();
    check("one_sat_held", sample_sat, 1);
    wait_strobe(64, n);
    check("one_sat_sample3", sample, 31);

    // Alternating bits: 16 per full frame
    do_reset(1, 0);
    wait_strobe(64, n);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(64, n);
      check("alt_period", n, 32);
      check("alt_sample", sample, 16);
      check("alt_sat", sample_sat, 0);
    end

    // Loopback from a sigma-delta source at 10/32 density
    do_reset(2, 0);
    sd_in = 10;
    wait_strobe(64, n);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(64, n);
      check("loop_in_range", int'(sample >= 9 && sample <= 11), 1);
    end

    // Stall of 7 cycles mid-frame
    do_reset(0, 1);
    for (int i = 0; i < 10; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("stall_no_strobe", sample_valid, 0);
    en = 1'b1;
    wait_strobe(64, n);
    total = 17 + n;
    check("stall_latency", total, 39);
    check("stall_sample", sample, 30);

    // Clear on the frame-end cycle
    do_reset(0, 1);
    wait_strobe(64, n);
    for (int i = 0; i < 31; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_no_strobe", sample_valid, 0);
    check("clear_sample_held", sample, 30);
    wait_strobe(64, n);
    check("clear_next_latency", n, 32);
    check("clear_next_sample", sample, 31);
    check("clear_next_sat", sample_sat, 1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("async_rst_sample", sample, 0);
    check("async_rst_sat", sample_sat, 0);
    check("async_rst_valid", sample_valid, 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pdm_demod.md
# pdm_demod

Decimating demodulator for the 1-bit PDM stream produced by the team's `pdm` modulator. It turns the stream back into WIDTH-bit samples by counting ones over fixed frames of 2^FRAME_LOG2 bits, scaling, and saturating. It sits at the input side of a user_module slot. Its main job is loopback or board-to-board checking of the modulator: feed `pdm_out` in and get `pdm_input` back out.

## Interface
- `WIDTH`, default 5: output sample width. Matches the modulator's 5-bit input.
- `FRAME_LOG2`, default 5: log2 of the frame length in bits. Must be ≥ WIDTH. An elaboration-time check errors otherwise.
- `clk`  input  1: sole clock. Rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `pdm_in`  input  1: PDM bitstream. May be asynchronous to `clk`.
- `en`  input  1: when low, the frame stalls. No counting and no frame advance.
- `clear`  input  1: synchronous restart of the current frame.
- `sample`  output  WIDTH: last completed demodulated sample.
- `sample_valid`  output  1: one-cycle strobe when `sample` updates.
- `sample_sat`  output  1: high while `sample` holds a saturated value.

## Operation
- **Synchronizer:** `pdm_in` passes through a 2-flop synchronizer. Its output `b` is the bit counted. The synchronizer always runs, regardless of `en` and `clear`.
- **State:** `frame_cnt` is FRAME_LOG2 bits. `acc` is FRAME_LOG2+1 bits.
- **Priority on each edge:** `clear` > `en`.
  - If `clear`: `frame_cnt` ← 0 and `acc` ← 0. `sample` is held. `sample_valid` ← 0.
  - Else if `!en`: all state is held. `sample_valid` ← 0.
  - Else if `frame_cnt` ≠ 2^FRAME_LOG2−1: `acc` ← `acc`+`b` and `frame_cnt` ← `frame_cnt`+1. `sample_valid` ← 0.
  - Else (frame end):
    - `t` = `acc`+`b`, giving 0..2^FRAME_LOG2.
    - `s` = `t` >> (FRAME_LOG2−WIDTH).
    - `sample` ← min(`s`, 2^WIDTH−1).
    - `sample_sat` ← (`s` > 2^WIDTH−1).
    - `sample_valid` ← 1.
    - `acc` ← 0 and `frame_cnt` wraps to 0.
- **Saturation:** only the all-ones frame saturates. With defaults, 32 ones gives 31 with `sample_sat`=1.
- **`sample_sat` lifetime:** it stays valid until the next frame end. It is cleared only by reset or by a non-saturated frame end.
- **Stalls:** an `en` stall mid-frame does not discard the partial count. Counting resumes where it left off.

## Timing
- **Reset values:** `sample`=0, `sample_valid`=0, `sample_sat`=0. Synchronizer flops, `frame_cnt` and `acc` are all 0.
- **Synchronizer latency:** a level on `pdm_in` reaches `b` after 2 `clk` edges.
- **Frame timing:** with `en` held high and no `clear`, `sample_valid` pulses exactly once every 2^FRAME_LOG2 cycles.
- **Strobe alignment:** `sample` and `sample_valid` change on the same edge. `sample_valid` is high for exactly one cycle.
- **First sample after reset:** on the 2^FRAME_LOG2-th enabled edge. The first 2 bits counted are the synchronizer's reset zeros.
- **`clear` on a frame-end cycle:** `clear` wins. No strobe is produced and `sample` is unchanged.
- **Reset mid-frame:** the partial frame is lost. Outputs return to reset values immediately (asynchronous).
- **Throughput:** one sample per frame. No backpressure. The consumer must capture on `sample_valid`.

## Structure
- **Shared package:** `pdm_pkg` holds `PDM_WIDTH`=5 and `PDM_FRAME_LOG2`=5. Both the `pdm` modulator and `pdm_demod` default their parameters from it.
- **Sub-module:** `sync2`, a 2-flop synchronizer with async active-high reset to 0. It is reused for other io_in pins.
- **Top level:** `pdm_demod` holds the counter, accumulator and output registers. There is no explicit FSM; `frame_cnt` is the sequencer.

## Test plan
All scenarios use default parameters.
- **Reset then constant 0:** `pdm_in`=0, `en`=1 for 64 cycles → two strobes 32 cycles apart, `sample`=0, `sample_sat`=0.
- **Constant 1 from reset:** `pdm_in`=1 from reset → first `sample`=30 (two synchronizer zeros), then 31 with `sample_sat`=1 on every later frame.
- **Alternating bits:** `pdm_in` alternating 1,0,… aligned to frames → `sample`=16 each frame, `sample_sat`=0.
- **Loopback:** drive the `pdm` modulator with 10 → `sample` settles to 10±1 on every frame after the first.
- **Stall:** drop `en` for 7 cycles mid-frame with `pdm_in`=1 → strobe delayed by exactly 7 cycles and the count is unchanged.
- **Clear and reset interrupts:**
  - Assert `clear` on the frame-end cycle → no strobe, `sample` held, next strobe 32 cycles later.
  - Assert `reset` mid-frame → all outputs are 0 immediately.
